mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single multi-cycle main memory between I-cache miss fills and D-cache fills/writes.
//  Fills issue one word read per cycle and stream returned words back to the owning cache.
//  D-cache writes are write-through, one word each. Sits between the fetch/MEM-stage caches and memory.
// PARAMETERS
//  WORDS_PER_BLOCK  8   words per cache block (power of 2); sets fill_word width
//  MEM_LAT          4   memory read latency in cycles; used by bench timing only
// PORTS
//  clk             in   1   clock
//  rst             in   1   async active-high reset
//  icache_req      in   1   I-cache fill request; held until icache_done
//  icache_addr     in   16  miss address (byte)
//  dcache_req      in   1   D-cache request; held until dcache_done
//  dcache_wr       in   1   1 = single-word write, 0 = block fill
//  dcache_addr     in   16  miss/write address (byte)
//  dcache_wdata    in   16  write data
//  mem_enable      out  1   memory access strobe
//  mem_wr          out  1   memory write
//  mem_addr        out  16  memory address
//  mem_data_in     out  16  memory write data
//  mem_data_out    in   16  memory read data
//  mem_data_valid  in   1   read data valid, MEM_LAT cycles after issue
//  fill_data       out  16  streamed fill word (= mem_data_out)
//  fill_word       out  3   index of word within block
//  fill_valid_i    out  1   fill_data belongs to I-cache
//  fill_valid_d    out  1   fill_data belongs to D-cache
//  icache_done     out  1   1-cycle pulse: I fill complete
//  dcache_done     out  1   1-cycle pulse: D fill/write complete
//  busy            out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, counters 0, last_grant = I. All outputs 0.
//  FSM: IDLE -> FILL | WRITE; FILL -> DONE after 8th valid; WRITE -> DONE; DONE -> IDLE.
//  Grant (IDLE only, takes effect next edge): D wins on a tie, unless last_grant = D and
//   icache_req = 1, then I wins. Owner, base address and wr are latched at grant.
//  FILL: issue_cnt 0..7 drives mem_enable = 1, mem_wr = 0,
//   mem_addr = {base[15:4], issue_cnt, 1'b0}, for 8 consecutive cycles; then no more issues.
//  FILL returns: combinational pass-through. Each mem_data_valid in FILL:
//   fill_data = mem_data_out, fill_word = recv_cnt, owner's fill_valid_x = 1; recv_cnt++.
//  WRITE: one cycle with mem_enable = 1, mem_wr = 1, mem_addr = latched addr,
//   mem_data_in = latched wdata.
//  DONE: owner's done = 1 for one cycle.
//  Timing at MEM_LAT = 4, with the req seen in cycle 0:
//   FILL issues in cycles 1-8; valids in 5-12; done in 13; IDLE in 14.
//   Write: WRITE in 1, done in 2.
//  Requester rule: req must be low in the cycle after its done. The IDLE cycle after DONE
//   re-arbitrates.
//  mem_data_valid outside FILL: ignored; no fill_valid_x asserted.
//  Counters are 3-bit and wrap; recv_cnt = 7 with valid is the terminal condition.
//  Address bits [3:1] of the request are ignored for fills; bit 0 is always 0 on mem_addr.
//  Reset mid-operation: immediate return to IDLE. Memory shares rst, so in-flight reads are
//   discarded; no done is issued.
//  Requests that change while not in IDLE are ignored until the next IDLE.
// STRUCTURE
//  Shared package: state encoding (IDLE, FILL, WRITE, DONE), WORDS_PER_BLOCK, OFFSET_BITS = 4.
//  One sub-module: arb_pick (combinational: icache_req, dcache_req, last_grant -> grant_i, grant_d).
// TESTING
//  1. I fill only, addr 16'h1236 -> mem_addr 1230, 1232, ... 123E in cycles 1-8;
//     fill_valid_i with fill_word 0-7 in cycles 5-12; icache_done in cycle 13.
//  2. D write, addr 16'h0040, data 16'hBEEF -> cycle 1: mem_enable = 1, mem_wr = 1,
//     mem_addr 0040, mem_data_in BEEF; dcache_done in cycle 2.
//  3. Both req in cycle 0, last_grant = I -> D serviced first; I granted in the IDLE after
//     dcache_done, with no gap beyond 1 cycle.
//  4. D fill done, then D and I both request -> I wins (anti-starvation), then D.
//  5. rst pulse in cycle 6 of a fill -> all outputs 0, busy = 0; late valids ignored;
//     a new I fill then completes normally with 8 words.
//  6. Spurious mem_data_valid in IDLE -> no fill_valid_i/d, no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D-cache main-memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned WORD_IDX_BITS   = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned OFFSET_BITS     = 4;

    localparam logic [WORD_IDX_BITS-1:0] LastWord = WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} arb_state_e;

    typedef enum logic {OwnerI = 1'b0, OwnerD = 1'b1} owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle of the arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                     icache_req;
    logic [15:0]              icache_addr;
    logic                     dcache_req;
    logic                     dcache_wr;
    logic [15:0]              dcache_addr;
    logic [15:0]              dcache_wdata;
    logic                     mem_enable;
    logic                     mem_wr;
    logic [15:0]              mem_addr;
    logic [15:0]              mem_data_in;
    logic [15:0]              mem_data_out;
    logic                     mem_data_valid;
    logic [15:0]              fill_data;
    logic [WORD_IDX_BITS-1:0] fill_word;
    logic                     fill_valid_i;
    logic                     fill_valid_d;
    logic                     icache_done;
    logic                     dcache_done;
    logic                     busy;

    // Arbiter side.
    modport slave (
        input  icache_req, icache_addr, dcache_req, dcache_wr, dcache_addr, dcache_wdata,
        input  mem_data_out, mem_data_valid,
        output mem_enable, mem_wr, mem_addr, mem_data_in,
        output fill_data, fill_word, fill_valid_i, fill_valid_d,
        output icache_done, dcache_done, busy
    );

    // Caches plus memory as seen from outside the arbiter.
    modport master (
        output icache_req, icache_addr, dcache_req, dcache_wr, dcache_addr, dcache_wdata,
        output mem_data_out, mem_data_valid,
        input  mem_enable, mem_wr, mem_addr, mem_data_in,
        input  fill_data, fill_word, fill_valid_i, fill_valid_d,
        input  icache_done, dcache_done, busy
    );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Grant selection: D wins a tie unless D was granted last and I is waiting.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   icache_req,
    input  logic   dcache_req,
    input  owner_e last_grant,
    output logic   grant_i,
    output logic   grant_d
);

    always_comb begin
        grant_d = dcache_req && !((last_grant == OwnerD) && icache_req);
        grant_i = icache_req && !grant_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares main memory between I-cache fills and D-cache fills / write-through writes.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_e               state_q, state_d;
    owner_e                   owner_q, last_grant_q, grant_owner;
    logic [15:0]              base_q, wdata_q;
    logic [WORD_IDX_BITS-1:0] issue_cnt_q, recv_cnt_q;
    logic                     issuing_q;
    logic                     grant_i, grant_d, granted, fill_ret;

    arb_pick u_arb_pick (
        .icache_req (bus.icache_req),
        .dcache_req (bus.dcache_req),
        .last_grant (last_grant_q),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    always_comb begin
        granted     = (state_q == StIdle) && (grant_i || grant_d);
        grant_owner = grant_d ? OwnerD : OwnerI;
        fill_ret    = (state_q == StFill) && bus.mem_data_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (granted) state_d = (grant_d && bus.dcache_wr) ? StWrite : StFill;
            StFill:  if (fill_ret && (recv_cnt_q == LastWord)) state_d = StDone;
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Transaction context is captured at grant; request lines are ignored afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= OwnerI;
            last_grant_q <= OwnerI;
            base_q       <= '0;
            wdata_q      <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            issuing_q    <= 1'b0;
        end else begin
            if (granted) begin
                owner_q      <= grant_owner;
                last_grant_q <= grant_owner;
                base_q       <= grant_d ? bus.dcache_addr : bus.icache_addr;
                wdata_q      <= bus.dcache_wdata;
                issue_cnt_q  <= '0;
                recv_cnt_q   <= '0;
                issuing_q    <= !(grant_d && bus.dcache_wr);
            end
            if (state_q == StFill) begin
                if (issuing_q) begin
                    issue_cnt_q <= issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LastWord) issuing_q <= 1'b0;
                end
                if (fill_ret) recv_cnt_q <= recv_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_enable   = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_data_in  = '0;
        bus.fill_data    = '0;
        bus.fill_word    = '0;
        bus.fill_valid_i = 1'b0;
        bus.fill_valid_d = 1'b0;
        bus.icache_done  = 1'b0;
        bus.dcache_done  = 1'b0;
        bus.busy         = (state_q != StIdle);
        unique case (state_q)
            StFill: begin
                if (issuing_q) begin
                    bus.mem_enable = 1'b1;
                    bus.mem_addr   = {base_q[15:OFFSET_BITS], issue_cnt_q, 1'b0};
                end
                if (bus.mem_data_valid) begin
                    bus.fill_data    = bus.mem_data_out;
                    bus.fill_word    = recv_cnt_q;
                    bus.fill_valid_i = (owner_q == OwnerI);
                    bus.fill_valid_d = (owner_q == OwnerD);
                end
            end
            StWrite: begin
                bus.mem_enable  = 1'b1;
                bus.mem_wr      = 1'b1;
                bus.mem_addr    = {base_q[15:1], 1'b0};
                bus.mem_data_in = wdata_q;
            end
            StDone: begin
                bus.icache_done = (owner_q == OwnerI);
                bus.dcache_done = (owner_q == OwnerD);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences, random traffic.
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;

    typedef struct packed {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] fdata;
        logic [2:0]  fword;
        logic        fvi;
        logic        fvd;
        logic        idone;
        logic        ddone;
        logic        busy;
    } obs_t;

    typedef struct {
        bit          ireq;
        logic [15:0] iaddr;
        bit          dreq;
        bit          dwr;
        logic [15:0] daddr;
        logic [15:0] wdata;
        bit          d_first;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   spur    = 1'b0;
    bit   flush_on_rst = 1'b1;
    bit   last_d  = 1'b0;
    rd_t  rd_q[$];

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return (a * 16'd7) ^ 16'h5A5A;
    endfunction

    // Memory model: reads return MEM_LAT cycles after the issue cycle.
    always @(negedge clk) begin
        if (rst && flush_on_rst) rd_q.delete();
        else if (!rst && bus.mem_enable && !bus.mem_wr) rd_q.push_back('{cyc + MEM_LAT, bus.mem_addr});
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data_out   = mdata(rd_q[0].addr);
            void'(rd_q.pop_front());
        end else if (spur) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data_out   = 16'h1234;
        end else begin
            bus.mem_data_valid = 1'b0;
            bus.mem_data_out   = '0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = '{bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.fill_data,
              bus.fill_word, bus.fill_valid_i, bus.fill_valid_d, bus.icache_done,
              bus.dcache_done, bus.busy};
        return o;
    endfunction

    task automatic check(input obs_t e, input string name);
        obs_t a;
        a = sample();
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, a, e);
        end
    endtask

    // From cycle 0 (request visible, arbiter idle) through the owner's done cycle.
    task automatic serve(input bit is_d, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata);
        obs_t e;
        int   n;
        n = wr ? 2 : 13;
        @(negedge clk);
        check('0, "grant_cycle");
        for (int t = 1; t <= n; t++) begin
            step();
            @(negedge clk);
            e = '0;
            e.busy = 1'b1;
            if (wr) begin
                if (t == 1) begin
                    e.en = 1'b1; e.wr = 1'b1; e.addr = addr & 16'hFFFE; e.din = wdata;
                end else e.ddone = 1'b1;
            end else begin
                if (t <= 8) begin
                    e.en   = 1'b1;
                    e.addr = {addr[15:4], 3'(t - 1), 1'b0};
                end
                if (t >= 5 && t <= 12) begin
                    e.fword = 3'(t - 5);
                    e.fdata = mdata({addr[15:4], 3'(t - 5), 1'b0});
                    if (is_d) e.fvd = 1'b1; else e.fvi = 1'b1;
                end
                if (t == 13) begin
                    if (is_d) e.ddone = 1'b1; else e.idone = 1'b1;
                end
            end
            check(e, wr ? "dwrite" : (is_d ? "dfill" : "ifill"));
        end
    endtask

    // Raise requests in the current cycle, serve winner then loser, end after an idle cycle.
    task automatic run_pair(input vec_t v);
        bus.icache_req   = v.ireq;
        bus.icache_addr  = v.iaddr;
        bus.dcache_req   = v.dreq;
        bus.dcache_wr    = v.dwr;
        bus.dcache_addr  = v.daddr;
        bus.dcache_wdata = v.wdata;
        if (v.d_first) begin
            serve(1'b1, v.dwr, v.daddr, v.wdata);
            step();
            bus.dcache_req = 1'b0;
            last_d = 1'b1;
            if (v.ireq) begin
                serve(1'b0, 1'b0, v.iaddr, 16'h0);
                step();
                bus.icache_req = 1'b0;
                last_d = 1'b0;
            end
        end else begin
            serve(1'b0, 1'b0, v.iaddr, 16'h0);
            step();
            bus.icache_req = 1'b0;
            last_d = 1'b0;
            if (v.dreq) begin
                serve(1'b1, v.dwr, v.daddr, v.wdata);
                step();
                bus.dcache_req = 1'b0;
                last_d = 1'b1;
            end
        end
        @(negedge clk);
        check('0, "idle_after");
        step();
    endtask

    vec_t vecs[5];

    initial begin
        vec_t v;
        vecs[0] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1};
        vecs[1] = '{1'b1, 16'h1236, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 16'h0A10, 1'b1, 1'b1, 16'h0052, 16'hCAFE, 1'b1};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h2004, 16'h0000, 1'b1};
        vecs[4] = '{1'b1, 16'h3008, 1'b1, 1'b0, 16'h4000, 16'h0000, 1'b0};

        bus.icache_req = 0; bus.icache_addr = 0; bus.dcache_req = 0; bus.dcache_wr = 0;
        bus.dcache_addr = 0; bus.dcache_wdata = 0;
        bus.mem_data_valid = 0; bus.mem_data_out = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check('0, "in_reset");
        step();
        rst = 1'b0;
        @(negedge clk);
        check('0, "after_reset");
        step();

        foreach (vecs[i]) run_pair(vecs[i]);

        // Spurious valid while idle.
        spur = 1'b1;
        step();
        spur = 1'b0;
        @(negedge clk);
        check('0, "spurious_valid");
        step();
        @(negedge clk);
        check('0, "spurious_after");
        step();

        // Reset in cycle 6 of an I fill; memory keeps its in-flight reads this time.
        bus.icache_req = 1'b1;
        bus.icache_addr = 16'h7770;
        repeat (6) step();
        flush_on_rst = 1'b0;
        rst = 1'b1;
        bus.icache_req = 1'b0;
        #1;
        check('0, "async_reset");
        step();
        rst = 1'b0;
        last_d = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check('0, "late_valid");
            step();
        end
        flush_on_rst = 1'b1;
        run_pair('{1'b1, 16'h7770, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0});

        // Random traffic against the arbitration rule.
        for (int i = 0; i < 30; i++) begin
            v.ireq    = 1'($urandom_range(0, 1));
            v.dreq    = v.ireq ? 1'($urandom_range(0, 1)) : 1'b1;
            v.dwr     = 1'($urandom_range(0, 1));
            v.iaddr   = 16'($urandom);
            v.daddr   = 16'($urandom);
            v.wdata   = 16'($urandom);
            v.d_first = v.dreq && !(last_d && v.ireq);
            run_pair(v);
            if ($urandom_range(0, 3) == 0) begin
                spur = 1'b1;
                step();
                spur = 1'b0;
                @(negedge clk);
                check('0, "rand_spurious");
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
